// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and widths for the two-requester memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE / REQ / WAIT)
//   owner_e     : which requester owns the outstanding transaction
//   ADDR_W, DATA_W, MASK_W : bus widths
//   other_owner : the requester that is not the given one
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_IFU) ? OWN_LSU : OWN_IFU;
    endfunction

endpackage

// File: rtl/arb_rr_sel.sv
// -----------------------------------------------------------------------------
// arb_rr_sel
// Combinational two-way round-robin grant. A lone requester always wins;
// when both request, the one that did not own the last transaction wins.
//   ifu_valid, lsu_valid : request pending from each requester
//   last_owner           : owner of the most recently completed transaction
//   grant_ifu, grant_lsu : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module arb_rr_sel
    import arb_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_owner,
    output logic   grant_ifu,
    output logic   grant_lsu
);

    owner_e winner_s;

    // Pick the grant from the pair of valids and the round-robin pointer
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        winner_s  = other_owner(last_owner);
        case ({ifu_valid, lsu_valid})
            2'b10: grant_ifu = 1'b1;
            2'b01: grant_lsu = 1'b1;
            2'b11: begin
                if (winner_s == OWN_IFU) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end
            default: begin
                grant_ifu = 1'b0;
                grant_lsu = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port (IFU) and a load/store port (LSU) onto
// a single downstream memory port, one transaction outstanding at a time.
//
// Ports
//   clk, rst                      : clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr : fetch request (read only)
//   ifu_resp_valid/rdata/resp_err : fetch response
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask
//                                 : load/store request
//   lsu_resp_valid/rdata/resp_err : load/store response
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask
//                                 : downstream request
//   mem_resp_valid, mem_rdata, mem_resp_err : downstream response
//
// Parameter TIMEOUT_CYCLES: WAIT cycles without a response before an error
// response is forced. Only active when the macro ARB_TIMEOUT_EN is defined;
// without it WAIT lasts until the memory responds.
//
// Request ready and response strobes are combinational so that a grant and a
// response each cost no extra cycle; the downstream request fields come
// straight from registers.
// -----------------------------------------------------------------------------
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    owner_e            owner_r;
    owner_e            last_owner_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wen_r;
    logic [DATA_W-1:0] wdata_r;
    logic [MASK_W-1:0] wmask_r;

    logic              grant_ifu_s;
    logic              grant_lsu_s;
    logic              resp_done_s;
    logic              tmo_hit_s;

    arb_rr_sel u_rr_sel (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_owner (last_owner_r),
        .grant_ifu  (grant_ifu_s),
        .grant_lsu  (grant_lsu_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    // WAIT-cycle counter: cleared on entry to WAIT, counts silent WAIT cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == REQ) && mem_req_ready) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == WAIT) && !mem_resp_valid && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // A real response in the same cycle wins over the timeout
    assign tmo_hit_s = (state_r == WAIT) && !mem_resp_valid &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched request fields and owner, captured on a grant in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r <= OWN_IFU;
            addr_r  <= {ADDR_W{1'b0}};
            wen_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {MASK_W{1'b0}};
        end else if ((state_r == IDLE) && grant_ifu_s) begin
            owner_r <= OWN_IFU;
            addr_r  <= ifu_addr;
            wen_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            wmask_r <= {MASK_W{1'b0}};
        end else if ((state_r == IDLE) && grant_lsu_s) begin
            owner_r <= OWN_LSU;
            addr_r  <= lsu_addr;
            wen_r   <= lsu_wen;
            wdata_r <= lsu_wdata;
            wmask_r <= lsu_wmask;
        end else begin
            owner_r <= owner_r;
            addr_r  <= addr_r;
            wen_r   <= wen_r;
            wdata_r <= wdata_r;
            wmask_r <= wmask_r;
        end
    end

    // Round-robin pointer; starts at LSU so IFU wins the first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_r <= OWN_LSU;
        end else if (resp_done_s) begin
            last_owner_r <= owner_r;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign mem_addr  = addr_r;
    assign mem_wen   = wen_r;
    assign mem_wdata = wdata_r;
    assign mem_wmask = wmask_r;

    // Next-state logic plus handshake and response outputs
    always_comb begin
        state_nxt_s    = state_r;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = {DATA_W{1'b0}};
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = {DATA_W{1'b0}};
        lsu_resp_err   = 1'b0;
        resp_done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // Ready is masked while reset is held so outputs read 0 at once
                ifu_req_ready = grant_ifu_s & rst;
                lsu_req_ready = grant_lsu_s & rst;
                if (grant_ifu_s || grant_lsu_s) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                if (mem_resp_valid || tmo_hit_s) begin
                    resp_done_s = 1'b1;
                    state_nxt_s = IDLE;
                    case (owner_r)
                        OWN_IFU: begin
                            ifu_resp_valid = 1'b1;
                            ifu_rdata      = mem_resp_valid ? mem_rdata : {DATA_W{1'b0}};
                            ifu_resp_err   = mem_resp_valid ? mem_resp_err : 1'b1;
                        end
                        OWN_LSU: begin
                            lsu_resp_valid = 1'b1;
                            lsu_rdata      = mem_resp_valid ? mem_rdata : {DATA_W{1'b0}};
                            lsu_resp_err   = mem_resp_valid ? mem_resp_err : 1'b1;
                        end
                        default: begin
                            resp_done_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (open / issued-to-memory / owner / round-robin pointer) predicts every
// output each cycle. Directed scenarios come first, then randomized traffic
// with occasional resets. Define ARB_TIMEOUT_EN to exercise the timeout.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: transaction-level view of the arbiter
    bit          m_open;     // a transaction has been granted and not answered
    bit          m_issued;   // memory has accepted the request
    bit          m_owner;    // 0 = IFU, 1 = LSU
    bit          m_last;     // owner of the last completed transaction
    logic [31:0] m_addr, m_wdata;
    bit          m_wen;
    logic [3:0]  m_wmask;
`ifdef ARB_TIMEOUT_EN
    int          m_wait;     // silent WAIT cycles so far
`endif

    mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open   = 1'b0;
        m_issued = 1'b0;
        m_owner  = 1'b0;
        m_last   = 1'b1;
        m_addr   = 32'h0;
        m_wdata  = 32'h0;
        m_wen    = 1'b0;
        m_wmask  = 4'h0;
`ifdef ARB_TIMEOUT_EN
        m_wait   = 0;
`endif
    endtask

    // One clock: check all outputs at negedge, advance the model at posedge,
    // then drop any requester valid that was just accepted.
    task automatic step();
        bit e_ifu_rdy, e_lsu_rdy, tmo, resp;
        @(negedge clk);
        if (!rst) model_reset();
        e_ifu_rdy = rst && !m_open && ifu_req_valid && (!lsu_req_valid || m_last);
        e_lsu_rdy = rst && !m_open && lsu_req_valid && (!ifu_req_valid || !m_last);
        tmo = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo = m_open && m_issued && !mem_resp_valid && (m_wait == TMO);
`endif
        resp = m_open && m_issued && (mem_resp_valid || tmo);

        check_eq("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
        check_eq("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
        check_eq("mem_req_valid", mem_req_valid, m_open && !m_issued);
        check_eq("mem_addr", mem_addr, m_addr);
        check_eq("mem_wen", mem_wen, m_wen);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("mem_wmask", mem_wmask, m_wmask);
        check_eq("ifu_resp_valid", ifu_resp_valid, resp && !m_owner);
        check_eq("ifu_rdata", ifu_rdata, (resp && !m_owner && mem_resp_valid) ? mem_rdata : 32'h0);
        check_eq("ifu_resp_err", ifu_resp_err,
                 (resp && !m_owner) ? (mem_resp_valid ? mem_resp_err : 1'b1) : 1'b0);
        check_eq("lsu_resp_valid", lsu_resp_valid, resp && m_owner);
        check_eq("lsu_rdata", lsu_rdata, (resp && m_owner && mem_resp_valid) ? mem_rdata : 32'h0);
        check_eq("lsu_resp_err", lsu_resp_err,
                 (resp && m_owner) ? (mem_resp_valid ? mem_resp_err : 1'b1) : 1'b0);

        @(posedge clk);
        if (rst) begin
            if (!m_open) begin
                if (e_ifu_rdy) begin
                    m_open = 1'b1; m_issued = 1'b0; m_owner = 1'b0;
                    m_addr = ifu_addr; m_wen = 1'b0; m_wdata = 32'h0; m_wmask = 4'h0;
                end else if (e_lsu_rdy) begin
                    m_open = 1'b1; m_issued = 1'b0; m_owner = 1'b1;
                    m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                end
            end else if (!m_issued) begin
                if (mem_req_ready) begin
                    m_issued = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    m_wait = 0;
`endif
                end
            end else if (resp) begin
                m_open = 1'b0;
                m_last = m_owner;
            end else begin
`ifdef ARB_TIMEOUT_EN
                m_wait++;
`endif
            end
        end
        #1;
        if (e_ifu_rdy) ifu_req_valid = 1'b0;
        if (e_lsu_rdy) lsu_req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = 32'h0; mem_resp_err = 1'b0;
        model_reset();

        // Reset state, with a request held to show ready stays low
        ifu_req_valid = 1'b1; ifu_addr = 32'h1234_5678;
        repeat (2) step();
        ifu_req_valid = 1'b0;
        step();
        rst = 1'b1;

        // IFU read, memory answers two cycles after the handshake
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        step();
        mem_req_ready = 1'b1; step();
        mem_req_ready = 1'b0; step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413; step();
        mem_resp_valid = 1'b0; step();

        // Contention right after reset: IFU first, then the LSU store
        rst = 1'b0; step(); rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0001;
        repeat (8) step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;

        // Downstream back-pressure for five cycles
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        step();
        repeat (5) step();
        mem_req_ready = 1'b1; step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1111_2222; step();
        mem_resp_valid = 1'b0; step();

        // LSU load returning a bus error
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        step();
        mem_req_ready = 1'b1; step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_err = 1'b1;
        mem_rdata = 32'hCAFE_F00D; step();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0; step();

        // Reset during WAIT, stale response afterwards, then a normal fetch
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        step();
        mem_req_ready = 1'b1; step();
        mem_req_ready = 1'b0; step();
        rst = 1'b0; step(); rst = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA; repeat (2) step();
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
        step();
        mem_req_ready = 1'b1; step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0513; step();
        mem_resp_valid = 1'b0; step();

        // Silent memory: timeout (when enabled) or indefinite WAIT, then a late response
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0400;
        step();
        mem_req_ready = 1'b1; step();
        mem_req_ready = 1'b0;
        repeat (TMO + 6) step();
        mem_resp_valid = 1'b1; mem_rdata = 32'h7777_0000; step();
        mem_resp_valid = 1'b0; repeat (2) step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            if (!ifu_req_valid && ($urandom_range(0, 1) == 1)) begin
                ifu_req_valid = 1'b1;
                ifu_addr      = $urandom;
            end
            if (!lsu_req_valid && ($urandom_range(0, 1) == 1)) begin
                lsu_req_valid = 1'b1;
                lsu_addr      = $urandom;
                lsu_wen       = 1'($urandom_range(0, 1));
                lsu_wdata     = $urandom;
                lsu_wmask     = 4'($urandom_range(0, 15));
            end
            mem_req_ready  = ($urandom_range(0, 2) != 0);
            mem_resp_valid = ($urandom_range(0, 2) == 0);
            mem_rdata      = $urandom;
            mem_resp_err   = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT-state cycles before forced error response (ARB_TIMEOUT_EN builds only).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ifu_req_valid  in  1  fetch request pending.
REQ-005 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-006 ifu_addr  in  32  fetch address.
REQ-007 ifu_resp_valid  out  1  fetch response strobe.
REQ-008 ifu_rdata  out  32  fetched instruction word.
REQ-009 ifu_resp_err  out  1  fetch bus error.
REQ-010 lsu_req_valid / lsu_req_ready  in / out  1  load-store request handshake.
REQ-011 lsu_addr  in  32; lsu_wen  in  1 (1=store); lsu_wdata  in  32; lsu_wmask  in  4  byte enables.
REQ-012 lsu_resp_valid  out  1; lsu_rdata  out  32; lsu_resp_err  out  1.
REQ-013 mem_req_valid  out  1; mem_req_ready  in  1  downstream request handshake.
REQ-014 mem_addr  out  32; mem_wen  out  1; mem_wdata  out  32; mem_wmask  out  4.
REQ-015 mem_resp_valid  in  1; mem_rdata  in  32; mem_resp_err  in  1.

Function
REQ-016 FSM states: IDLE, REQ, WAIT; one transaction outstanding at a time.
REQ-017 IDLE, exactly one requester valid: assert its req_ready combinationally that cycle, latch addr/wen/wdata/wmask and owner, next state REQ.
REQ-018 IDLE, both valid: grant the requester not equal to last_owner (round-robin); the loser's req_ready stays 0.
REQ-019 IFU grants latch mem_wen=0, mem_wdata=0, mem_wmask=0.
REQ-020 REQ: mem_req_valid=1 driving latched fields, held stable until mem_req_ready=1; then next state WAIT.
REQ-021 WAIT: on mem_resp_valid=1, drive owner's resp_valid=1, rdata=mem_rdata, resp_err=mem_resp_err in that same cycle (combinational); next state IDLE; update last_owner.
REQ-022 Non-owner resp_valid=0 and rdata=0 at all times; mem_resp_valid outside WAIT is ignored.
REQ-023 Minimum transaction: accept T, mem_req_valid T+1, earliest response T+2, next grant T+3.
REQ-024 req_ready outputs are 0 in REQ and WAIT; requester valid may be held without effect.

Reset
REQ-025 rst low: state=IDLE, last_owner=LSU (IFU wins first contention), latched fields=0, timeout counter=0, all outputs 0, effective immediately.
REQ-026 Reset mid-transaction abandons it; no response issued; later mem_resp_valid ignored in IDLE.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: counter clears on entry to WAIT, increments each WAIT cycle without mem_resp_valid; reaching TIMEOUT_CYCLES forces owner resp_valid=1, resp_err=1, rdata=0, next state IDLE; response arriving on the same cycle takes precedence (normal response).
REQ-028 Macro undefined: no counter; WAIT persists indefinitely until mem_resp_valid.

Structure
REQ-029 Package arb_pkg: state enum (IDLE/REQ/WAIT), owner enum (OWN_IFU/OWN_LSU), ADDR_W=32, DATA_W=32, MASK_W=4.
REQ-030 Sub-module arb_rr_sel: combinational two-way round-robin grant from two valids and last_owner.

Verification
REQ-031 IFU-only read addr 0x80000000, memory responds rdata 0x00000413 two cycles after handshake -> ifu_resp_valid one cycle, ifu_rdata=0x00000413, lsu_resp_valid never 1.
REQ-032 Both valid in IDLE after reset -> IFU granted first; LSU (store 0x80001000, wdata 0xDEADBEEF, wmask 0xF) granted in next IDLE with mem_wen=1.
REQ-033 mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_addr stable all 5 cycles; WAIT entered after ready.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> owner resp_valid=1, resp_err=1 after 8 WAIT cycles; late mem_resp_valid ignored.
REQ-035 rst low during WAIT, then mem_resp_valid -> no resp_valid to either requester; outputs 0; next IFU request served normally.
REQ-036 LSU load with mem_resp_err=1 -> lsu_resp_err=1, lsu_rdata=mem_rdata same cycle.
